// File: rtl/neuron_wb_pkg.sv
// Shared types and constants for the neuron core Wishbone front-end.
// Region codes select on adr[13:12] within the BASE_HI window.
package neuron_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StSynWait,
    StResp
  } state_e;

  localparam logic [15:0] BASE_HI = 16'h3000;

  typedef enum logic [1:0] {
    RegSyn   = 2'd0,
    RegParam = 2'd1,
    RegSpike = 2'd2,
    RegCtrl  = 2'd3
  } region_e;

  localparam logic [31:0] DONE_PIC_ADDR = 32'h3000_3100;
  localparam logic [1:0]  PARAM_WORDS   = 2'd3;

  typedef struct packed {
    logic syn;
    logic param;
    logic spike;
    logic cw;
    logic done;
    logic unmapped;
  } dec_t;

endpackage

// File: rtl/neuron_wb_slave_address_decoder.sv
// Classifies a captured Wishbone address into one neuron-core target.
// Pure bit slicing; exactly one field of dec_o is set.
module address_decoder
  import neuron_wb_pkg::*;
#(
  parameter logic [15:0] BaseHi = BASE_HI
) (
  input  logic [31:0] adr_i,
  output dec_t        dec_o
);

  logic    base_ok;
  region_e region;

  always_comb begin
    base_ok = (adr_i[31:16] == BaseHi) && (adr_i[15:14] == 2'b00);
    region  = region_e'(adr_i[13:12]);
    dec_o   = '0;
    if (base_ok) begin
      unique case (region)
        RegSyn:   dec_o.syn   = (adr_i[11:10] == 2'b00);
        RegParam: dec_o.param = (adr_i[3:2] < PARAM_WORDS);
        RegSpike: dec_o.spike = 1'b1;
        RegCtrl: begin
          dec_o.cw   = (adr_i[11:6] == 6'd0);
          dec_o.done = (adr_i[13:0] == DONE_PIC_ADDR[13:0]);
        end
        default: dec_o = '0;
      endcase
    end
    dec_o.unmapped = ~(dec_o.syn | dec_o.param | dec_o.spike | dec_o.cw | dec_o.done);
  end

endmodule

// File: rtl/neuron_wb_slave.sv
// Wishbone classic slave front-end for the 256x256 neuron core.
// Define NEURON_WB_ERR_EN to terminate unmapped accesses with wbs_err_o.
module neuron_wb_slave #(
  parameter logic [15:0] BASE_HI = neuron_wb_pkg::BASE_HI,
  parameter int unsigned SYN_AW  = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic [31:0]       wbs_dat_o,
  output logic              syn_en_o,
  output logic              syn_we_o,
  output logic [SYN_AW-1:0] syn_addr_o,
  output logic [3:0]        syn_wmask_o,
  output logic [31:0]       syn_wdata_o,
  input  logic [31:0]       syn_rdata_i,
  output logic              param_we_o,
  output logic [4:0]        param_num_o,
  output logic [1:0]        param_word_o,
  output logic [31:0]       param_wdata_o,
  input  logic [31:0]       param_rdata_i,
  input  logic [31:0]       spike_rdata_i,
  output logic              cw_we_o,
  output logic [3:0]        cw_idx_o,
  output logic [31:0]       cw_wdata_o,
  output logic              pic_done_o
);

  import neuron_wb_pkg::*;

`ifdef NEURON_WB_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  dec_t        dec;
  logic        in_decode;
  logic        sel_full;
  logic [31:0] rd_mux;

  address_decoder #(
    .BaseHi(BASE_HI)
  ) u_address_decoder (
    .adr_i(adr_q),
    .dec_o(dec)
  );

  assign in_decode = (state_q == StDecode);
  assign sel_full  = (sel_q == 4'hF);

  // Target strobes exist only in DECODE, so they last exactly one cycle.
  assign syn_en_o   = in_decode & dec.syn;
  assign syn_we_o   = in_decode & dec.syn & we_q;
  assign param_we_o = in_decode & dec.param & we_q & sel_full;
  assign cw_we_o    = in_decode & dec.cw & we_q & sel_full;
  assign pic_done_o = in_decode & dec.done & we_q;

  assign syn_addr_o    = adr_q[SYN_AW+1:2];
  assign syn_wmask_o   = sel_q;
  assign syn_wdata_o   = wdat_q;
  assign param_num_o   = adr_q[8:4];
  assign param_word_o  = adr_q[3:2];
  assign param_wdata_o = wdat_q;
  assign cw_idx_o      = adr_q[5:2];
  assign cw_wdata_o    = wdat_q;

  // Gating with cyc suppresses termination when the master aborts in RESP.
  assign wbs_ack_o = ack_q & wbs_cyc_i;
  assign wbs_err_o = ErrEn & err_q & wbs_cyc_i;
  assign wbs_dat_o = wbs_ack_o ? rdata_q : 32'h0;

  always_comb begin
    rd_mux = 32'h0;
    if (dec.param) begin
      rd_mux = param_rdata_i;
    end else if (dec.spike) begin
      rd_mux = spike_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d   = wbs_adr_i;
          wdat_d  = wbs_dat_i;
          sel_d   = wbs_sel_i;
          we_d    = wbs_we_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (dec.syn && !we_q) begin
          state_d = StSynWait;
        end else begin
          rdata_d = we_q ? 32'h0 : rd_mux;
          err_d   = ErrEn & dec.unmapped;
          ack_d   = ~err_d;
          state_d = StResp;
        end
      end
      StSynWait: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else begin
          rdata_d = syn_rdata_i;
          ack_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      sel_q   <= 4'h0;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_neuron_wb_slave.sv
// Self-checking bench for neuron_wb_slave: directed and random bus transfers
// against an address-map model and a behavioural synapse memory.
module tb_neuron_wb_slave;

`ifdef NEURON_WB_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat = 32'h0;
  logic        ack, err;
  logic [31:0] dat_o;
  logic        syn_en, syn_we;
  logic [7:0]  syn_addr;
  logic [3:0]  syn_wmask;
  logic [31:0] syn_wdata;
  logic [31:0] syn_rdata = 32'h0;
  logic        param_we;
  logic [4:0]  param_num;
  logic [1:0]  param_word;
  logic [31:0] param_wdata;
  logic [31:0] param_rdata = 32'h0, spike_rdata = 32'h0;
  logic        cw_we;
  logic [3:0]  cw_idx;
  logic [31:0] cw_wdata;
  logic        pic_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sram [256] = '{default: 32'h0};
  logic [31:0] model_mem [256] = '{default: 32'h0};

  always #5 clk = ~clk;

  neuron_wb_slave #(
    .BASE_HI(16'h3000),
    .SYN_AW (8)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat),
    .wbs_ack_o    (ack),
    .wbs_err_o    (err),
    .wbs_dat_o    (dat_o),
    .syn_en_o     (syn_en),
    .syn_we_o     (syn_we),
    .syn_addr_o   (syn_addr),
    .syn_wmask_o  (syn_wmask),
    .syn_wdata_o  (syn_wdata),
    .syn_rdata_i  (syn_rdata),
    .param_we_o   (param_we),
    .param_num_o  (param_num),
    .param_word_o (param_word),
    .param_wdata_o(param_wdata),
    .param_rdata_i(param_rdata),
    .spike_rdata_i(spike_rdata),
    .cw_we_o      (cw_we),
    .cw_idx_o     (cw_idx),
    .cw_wdata_o   (cw_wdata),
    .pic_done_o   (pic_done)
  );

  // Synapse SRAM: one-cycle read latency, byte-masked write.
  always @(posedge clk) begin
    if (syn_en) begin
      if (syn_we) begin
        for (int b = 0; b < 4; b++) begin
          if (syn_wmask[b]) sram[syn_addr][b*8 +: 8] <= syn_wdata[b*8 +: 8];
        end
      end
      syn_rdata <= sram[syn_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Address map: 0 unmapped, 1 synapse, 2 param, 3 spike, 4 choose-weight, 5 picture-done.
  function automatic int cls(input logic [31:0] a);
    int unsigned off;
    off = a & 32'hFFFF;
    if ((a >> 16) != 32'h3000) return 0;
    if (off < 'h400) return 1;
    if (off >= 'h1000 && off < 'h2000) return (((off >> 2) % 4) == 3) ? 0 : 2;
    if (off >= 'h2000 && off < 'h3000) return 3;
    if (off >= 'h3000 && off < 'h3040) return 4;
    if (a == 32'h3000_3100) return 5;
    return 0;
  endfunction

  task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                      input logic [3:0] s, input logic [31:0] d);
    int          c, idx, exp_k, got_k;
    logic [4:0]  exp_stb, obs_stb, extra;
    logic        exp_err, got_ack, got_err, stray_dat;
    logic [31:0] exp_dat, got_dat, m;
    logic [159:0] f_obs, f_exp;
    c       = cls(a);
    idx     = (a >> 2) % 256;
    exp_stb = {c == 1, c == 1 && w, c == 2 && w && s == 4'hF, c == 4 && w && s == 4'hF,
               c == 5 && w};
    exp_k   = (c == 1 && !w) ? 3 : 2;
    exp_err = ErrEn && (c == 0);
    exp_dat = 32'h0;
    if (!w) begin
      if (c == 1) exp_dat = model_mem[idx];
      else if (c == 2) exp_dat = param_rdata;
      else if (c == 3) exp_dat = spike_rdata;
    end
    f_exp = {8'(a >> 2), s, 5'(a >> 4), 2'(a >> 2), 4'(a >> 2), d, d, d};
    f_obs = '0;
    obs_stb = '0; extra = '0; got_k = 0; got_ack = 0; got_err = 0; got_dat = '0;
    stray_dat = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        obs_stb = {syn_en, syn_we, param_we, cw_we, pic_done};
        f_obs = {syn_addr, syn_wmask, param_num, param_word, cw_idx,
                 syn_wdata, param_wdata, cw_wdata};
      end else begin
        extra |= {syn_en, syn_we, param_we, cw_we, pic_done};
      end
      if (got_k == 0 && (ack || err)) begin
        got_k = k; got_ack = ack; got_err = err; got_dat = dat_o;
        cyc = 0; stb = 0; we = 0;
      end else if (dat_o != 32'h0) begin
        stray_dat = 1;
      end
    end
    cyc = 0; stb = 0; we = 0;
    chk({tag, ".strobes"}, 160'(obs_stb), 160'(exp_stb));
    chk({tag, ".fields"}, f_obs, f_exp);
    chk({tag, ".extra_strobes"}, 160'(extra), 160'd0);
    chk({tag, ".term_cycle"}, 160'(got_k), 160'(exp_k));
    chk({tag, ".ack_err"}, 160'({got_ack, got_err}), 160'({!exp_err, exp_err}));
    chk({tag, ".rdata"}, 160'(got_dat), 160'(exp_dat));
    chk({tag, ".dat_idle"}, 160'(stray_dat), 160'd0);
    if (c == 1 && w) begin
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      model_mem[idx] = (model_mem[idx] & ~m) | (d & m);
    end
  endtask

  initial begin
    logic [31:0] off, a;
    logic [15:0] hi;
    #2;
    chk("reset.outs_a", 160'({ack, err, dat_o, syn_en, syn_we, syn_addr, syn_wmask, syn_wdata,
                               param_we, param_num, param_word}), 160'd0);
    chk("reset.outs_b", 160'({param_wdata, cw_we, cw_idx, cw_wdata, pic_done}), 160'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    xfer("syn_wr", 32'h3000_0010, 1, 4'hF, 32'hDEAD_BEEF);
    xfer("syn_rd", 32'h3000_0010, 0, 4'hF, 32'h0);
    xfer("param_wr_full", 32'h3000_1128, 1, 4'hF, 32'h1234_5678);
    xfer("param_wr_part", 32'h3000_1128, 1, 4'h3, 32'h1234_5678);
    param_rdata = 32'hCAFE_0001;
    xfer("param_rd", 32'h3000_1124, 0, 4'hF, 32'h0);
    xfer("param_w3_rd", 32'h3000_100C, 0, 4'hF, 32'h0);
    xfer("pic_done", 32'h3000_3100, 1, 4'h1, 32'hFFFF_FFFF);
    xfer("pic_done_rd", 32'h3000_3100, 0, 4'hF, 32'h0);
    spike_rdata = 32'h0000_00A5;
    xfer("spike_rd", 32'h3000_2000, 0, 4'hF, 32'h0);
    xfer("unmapped_rd", 32'h3100_0000, 0, 4'hF, 32'h0);
    xfer("syn_hole_wr", 32'h3000_0410, 1, 4'hF, 32'h5555_AAAA);
    xfer("cw_wr", 32'h3000_3024, 1, 4'hF, 32'h0BAD_F00D);
    xfer("cw_wr_part", 32'h3000_3024, 1, 4'hC, 32'h0BAD_F00D);
    xfer("cw_rd", 32'h3000_3024, 0, 4'hF, 32'h0);

    // Abort a synapse read while the SRAM data is pending.
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0010; sel = 4'hF;
    @(negedge clk);
    chk("abort.syn_en", 160'(syn_en), 160'd1);
    @(negedge clk);
    chk("abort.no_term", 160'({ack, err}), 160'd0);
    cyc = 0; stb = 0;
    xfer("post_abort", 32'h3000_0020, 1, 4'hF, 32'h0102_0304);

    // Reset in the strobe cycle.
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h3000_0044; dat = 32'h7777_8888; sel = 4'hF;
    @(negedge clk);
    chk("rst_mid.syn_en", 160'(syn_en), 160'd1);
    rst_n = 0;
    #1;
    chk("rst_mid.outs_a", 160'({ack, err, dat_o, syn_en, syn_we, syn_addr, syn_wmask, syn_wdata,
                                 param_we, param_num, param_word}), 160'd0);
    chk("rst_mid.outs_b", 160'({param_wdata, cw_we, cw_idx, cw_wdata, pic_done}), 160'd0);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    rst_n = 1;
    xfer("post_reset_rd", 32'h3000_0044, 0, 4'hF, 32'h0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    off = $urandom_range(0, 255) * 4;
        2:       off = 'h1000 + $urandom_range(0, 1023) * 4;
        3:       off = 'h2000 + $urandom_range(0, 1023) * 4;
        4:       off = 'h3000 + $urandom_range(0, 15) * 4;
        5:       off = 'h3100;
        default: off = $urandom_range(0, 16383) * 4;
      endcase
      hi = ($urandom_range(0, 9) == 0) ? 16'h3100 : 16'h3000;
      a = {hi, off[15:0]};
      param_rdata = $urandom;
      spike_rdata = $urandom;
      xfer("rand", a, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_wb_slave.md
# neuron_wb_slave

Wishbone classic slave front-end for the 256x256 neuron core. It sits between the Caravel user-project Wishbone port and the core's storage: it captures each bus request and classifies the registered address with the core's `address_decoder`. It then issues single-cycle strobes to the synapse SRAM, parameter bank, choose-weight registers and picture-done event, and returns `wbs_ack_o` with read data. All bus timing, wait-state and abort handling for the core lives here.

## Interface
Parameters:
- `BASE_HI`, default 16'h3000: required value of `wbs_adr_i[31:16]`.
- `SYN_AW`, default 8: synapse word-address width (256 words, 0x000–0x3FF).

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_n` in 1: reset, asynchronous, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone request.
- `wbs_sel_i` in 4: byte selects.
- `wbs_adr_i`, `wbs_dat_i` in 32: address and write data.
- `wbs_ack_o` out 1: normal termination.
- `wbs_err_o` out 1: error termination.
- `wbs_dat_o` out 32: read data.
- `syn_en_o`, `syn_we_o` out 1: synapse SRAM enable and write.
- `syn_addr_o` out SYN_AW: `adr[9:2]`.
- `syn_wmask_o` out 4: byte mask, equal to `sel`.
- `syn_wdata_o` out 32: synapse write data.
- `syn_rdata_i` in 32: synapse read data, valid 1 cycle after `syn_en_o`.
- `param_we_o` out 1: parameter write.
- `param_num_o` out 5: neuron index.
- `param_word_o` out 2: `adr[3:2]`.
- `param_wdata_o` out 32: parameter write data.
- `param_rdata_i` in 32: combinational read of the selected parameter word.
- `spike_rdata_i` in 32: spike-out word.
- `cw_we_o` out 1: choose-weight write.
- `cw_idx_o` out 4: `adr[5:2]`.
- `cw_wdata_o` out 32: choose-weight write data.
- `pic_done_o` out 1: one-cycle picture-done pulse.

## Operation
- FSM states: IDLE, DECODE, SYN_WAIT, RESP.
- IDLE: on `cyc&stb`, register adr, dat, sel and we into capture registers, then go to DECODE. The decoder input is the captured address, never the live bus.
- DECODE: at most one target strobe is issued, for exactly this cycle.
  - Synapse: `syn_en_o`=1, and `syn_we_o`=we. Reads go to SYN_WAIT; writes go to RESP.
  - Parameter write: `param_we_o` only when `sel`==4'hF and word<3. Otherwise the write is dropped.
  - Choose-weight write: `cw_we_o` only when `sel`==4'hF.
  - Write to exactly 0x3000_3100: `pic_done_o` pulses for one cycle. Write data is ignored.
  - Reads of parameter, spike, choose-weight (returns 0, write-only) and picture-done (returns 0): data is latched into the `wbs_dat_o` register, then go to RESP.
- SYN_WAIT: latch `syn_rdata_i` and go to RESP.
- RESP: assert `wbs_ack_o` (or `wbs_err_o`) for one cycle, then return to IDLE.
- Unmapped targets are write-dropped and read as 32'h0:
  - `adr[31:16]`≠BASE_HI;
  - `adr[15:14]`≠0;
  - synapse region with `adr[11:10]`≠0;
  - parameter word 3;
  - region 3 hitting neither choose-weight nor done.
- Abort: if `cyc` drops in DECODE, SYN_WAIT or RESP, go to IDLE without terminating. A strobe already issued is not undone.
- Address arithmetic: pure bit slicing; no adders.

## Timing
- Reset: every output is 0, the FSM is in IDLE, and the capture registers are 0.
- Cycle 0 is the first edge sampling `cyc&stb` in IDLE.
  - Target strobes are high in cycle 1.
  - Ack/err is high in cycle 2 for all writes and non-synapse reads, and in cycle 3 for synapse reads.
- `wbs_dat_o` is valid exactly while `wbs_ack_o`=1. It is 0 otherwise and for all writes.
- Back-to-back: a request held or re-asserted on the cycle after ack is sampled in IDLE on that cycle. Peak rate is 1 transfer per 3 cycles (per 4 for synapse reads).
- `wbs_ack_o` and `wbs_err_o` are never high together, and never for more than one cycle.
- Reset asserted mid-transaction: outputs clear immediately (asynchronously) and no termination is sent.

## Configuration
- `NEURON_WB_ERR_EN`:
  - Defined: unmapped accesses terminate with `wbs_err_o` instead of `wbs_ack_o`. Writes are still dropped and read data is 0.
  - Undefined: every access terminates with `wbs_ack_o`, and `wbs_err_o` is tied to 0. The port remains present.

## Structure
- Shared package `neuron_wb_pkg`:
  - FSM state enum;
  - `BASE_HI`;
  - region codes for `adr[13:12]`;
  - DONE_PIC_ADDR 32'h3000_3100;
  - parameter word count (3).
- One sub-module instance: `address_decoder`, fed by the capture address register. Its outputs are used only in DECODE.

## Test plan
- Write 0x3000_0010 with data 0xDEADBEEF and sel F → `syn_en_o`=`syn_we_o`=1 and `syn_addr_o`=4 in cycle 1; ack in cycle 2.
- Read 0x3000_0010 with SRAM returning 0xDEADBEEF → `syn_en_o` in cycle 1; ack with `wbs_dat_o`=0xDEADBEEF in cycle 3.
- Parameter access:
  - Write 0x3000_1128 with sel F → `param_we_o`=1, `param_num_o`=18, `param_word_o`=2.
  - Same write with sel 4'h3 → no `param_we_o`, but still acked.
- Write 0x3000_3100 → `pic_done_o` is high for exactly 1 cycle.
- Read 0x3000_2000 with `spike_rdata_i`=0x0000_00A5 → ack in cycle 2 with 0xA5.
  - Read 0x3100_0000 → err with `NEURON_WB_ERR_EN` defined; ack with data 0 without it.
- Abort and reset:
  - Drop `cyc` in SYN_WAIT → no ack, FSM in IDLE.
  - Assert `wb_rst_n`=0 mid-DECODE → all outputs 0 immediately.
